// File: rtl/ln_subtract_block.sv
// Log-softmax output stage: buffers one frame of (x - max) samples,
// then drains them minus ln(sum exp) with signed saturation.
module ln_subtract_block #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] sub_data_i,
  input  logic                 sub_data_valid_i,
  input  logic [data_size-1:0] ln_data_i,
  input  logic                 ln_data_valid_i,
  output logic [data_size-1:0] norm_data_o,
  output logic                 norm_data_valid_o,
  output logic                 norm_done_o,
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam int pw =
    (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam logic [pw-1:0] last_idx =
    pw'(number_of_data - 1);
  localparam logic [data_size-1:0] max_pos =
    {1'b0, {(data_size-1){1'b1}}};
  localparam logic [data_size-1:0] min_neg =
    {1'b1, {(data_size-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_LN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [data_size-1:0] buffer [number_of_data];
  logic [pw-1:0]        wr_ptr;
  logic [pw-1:0]        rd_ptr;
  logic                 ln_held;
  logic [data_size-1:0] ln_reg;

  logic                 wr_en;
  logic                 ln_cap;
  logic                 ln_early;
  logic                 drop;
  logic                 rd_last;
  logic [data_size-1:0] rd_data;
  logic signed [data_size:0] diff;
  logic [data_size-1:0] sat;

  assign rd_data = buffer[rd_ptr];
  assign rd_last = (rd_ptr == last_idx);
  assign diff =
    $signed({rd_data[data_size-1], rd_data}) -
    $signed({ln_reg[data_size-1], ln_reg});

  // Top two bits of the widened difference disagree only on overflow.
  always_comb begin
    sat = diff[data_size-1:0];
    unique case (1'b1)
      diff[data_size] & ~diff[data_size-1]: sat = min_neg;
      ~diff[data_size] & diff[data_size-1]: sat = max_pos;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    ln_cap    = 1'b0;
    ln_early  = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (sub_data_valid_i) begin
          wr_en     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        wr_en    = sub_data_valid_i;
        ln_cap   = ln_data_valid_i;
        ln_early = ln_data_valid_i;
        if (sub_data_valid_i && wr_ptr == last_idx) begin
          if (ln_held || ln_data_valid_i)
            state_nxt = DRAIN;
          else
            state_nxt = WAIT_LN;
        end
      end
      WAIT_LN: begin
        drop   = sub_data_valid_i;
        ln_cap = ln_data_valid_i;
        if (ln_data_valid_i)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        drop = sub_data_valid_i;
        if (rd_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (wr_en)
      buffer[wr_ptr] <= sub_data_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      ln_held           <= 1'b0;
      ln_reg            <= '0;
      norm_data_o       <= '0;
      norm_data_valid_o <= 1'b0;
      norm_done_o       <= 1'b0;
      busy_o            <= 1'b0;
      drop_o            <= 1'b0;
    end else begin
      state             <= state_nxt;
      busy_o            <= (state_nxt != IDLE);
      drop_o            <= drop;
      norm_data_valid_o <= (state == DRAIN);
      norm_done_o       <= (state == DRAIN) && rd_last;
      if (wr_en)
        wr_ptr <= wr_ptr + pw'(1);
      if (ln_cap)
        ln_reg <= ln_data_i;
      if (ln_early)
        ln_held <= 1'b1;
      if (state == DRAIN) begin
        norm_data_o <= sat;
        if (rd_last) begin
          rd_ptr  <= '0;
          wr_ptr  <= '0;
          ln_held <= 1'b0;
        end else begin
          rd_ptr <= rd_ptr + pw'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ln_subtract_block.sv
// Directed + randomized bench for ln_subtract_block with a
// frame-level saturating-subtract reference model.
module tb_ln_subtract_block;

  localparam int W = 32;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sub_d = '0;
  logic         sub_v = 1'b0;
  logic [W-1:0] ln_d = '0;
  logic         ln_v = 1'b0;
  logic [W-1:0] nd;
  logic         nv;
  logic         ndone;
  logic         busy;
  logic         drop;

  always #5 clk = ~clk;

  ln_subtract_block #(
    .data_size(W),
    .number_of_data(N)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .sub_data_i(sub_d),
    .sub_data_valid_i(sub_v),
    .ln_data_i(ln_d),
    .ln_data_valid_i(ln_v),
    .norm_data_o(nd),
    .norm_data_valid_o(nv),
    .norm_done_o(ndone),
    .busy_o(busy),
    .drop_o(drop)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int drop_cnt = 0;
  logic [W-1:0] out_q[$];
  int           ocyc_q[$];
  bit           done_q[$];
  logic [W-1:0] fr[N];
  logic [W-1:0] exp_v[N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nv) begin
      out_q.push_back(nd);
      ocyc_q.push_back(cyc);
      done_q.push_back(ndone);
    end
    if (drop) drop_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] ref_sub(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (d < -64'sd2147483648) return 32'h8000_0000;
    return d[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    out_q.delete();
    ocyc_q.delete();
    done_q.delete();
    drop_cnt = 0;
  endtask

  task automatic send(input logic [W-1:0] x);
    sub_v = 1'b1;
    sub_d = x;
    tick();
    last_cyc = cyc;
    sub_v = 1'b0;
    sub_d = $urandom();
  endtask

  task automatic strobe_ln(input logic [W-1:0] l, output int cap);
    ln_v = 1'b1;
    ln_d = l;
    tick();
    cap = cyc;
    ln_v = 1'b0;
    ln_d = $urandom();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) fr[i] = $urandom();
  endtask

  task automatic check_frame(
    input string        tag,
    input logic [W-1:0] ln,
    input int           start
  );
    for (int i = 0; i < N; i++) exp_v[i] = ref_sub(fr[i], ln);
    for (int t = 0; t < 60 && out_q.size() < N; t++) tick();
    repeat (3) tick();
    chk({tag, "_count"}, out_q.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < out_q.size()) begin
        chk($sformatf("%s_val%0d", tag, i), out_q[i], exp_v[i]);
        chk($sformatf("%s_cyc%0d", tag, i), ocyc_q[i], start + i);
        chk($sformatf("%s_done%0d", tag, i), done_q[i], i == N - 1);
      end
    end
    chk({tag, "_idle"}, busy, 1'b0);
    clear();
  endtask

  initial begin
    int cap;
    bit busy_ok;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_data", nd, 0);
    chk("rst_valid", nv, 0);
    chk("rst_done", ndone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1;
    tick();
    clear();

    // 1: fill, wait for ln, drain
    for (int k = 0; k < N; k++) fr[k] = 32'(k) << 16;
    for (int k = 0; k < N; k++) send(fr[k]);
    repeat (3) tick();
    chk("t1_wait_noout", out_q.size(), 0);
    chk("t1_wait_busy", busy, 1'b1);
    strobe_ln(32'(2) << 16, cap);
    check_frame("t1", 32'(2) << 16, cap + 1);

    // 2: early ln (overwritten once), no stall
    for (int k = 0; k < N; k++) fr[k] = 32'(k) << 16;
    for (int k = 0; k < 3; k++) send(fr[k]);
    strobe_ln(32'(1) << 16, cap);
    for (int k = 3; k < 5; k++) send(fr[k]);
    strobe_ln(32'(3) << 16, cap);
    for (int k = 5; k < N; k++) send(fr[k]);
    check_frame("t2", 32'(3) << 16, last_cyc + 1);

    // 3a: negative saturation
    fill_rand();
    fr[0] = 32'h8000_0001;
    for (int k = 0; k < N; k++) send(fr[k]);
    strobe_ln(32'h0000_0010, cap);
    check_frame("t3a", 32'h0000_0010, cap + 1);

    // 3b: positive saturation, ln with final sample
    fill_rand();
    fr[N-1] = 32'h7FFF_FFF0;
    for (int k = 0; k < N - 1; k++) send(fr[k]);
    sub_v = 1'b1;
    sub_d = fr[N-1];
    ln_v = 1'b1;
    ln_d = 32'hFFFF_FF00;
    tick();
    cap = cyc;
    sub_v = 1'b0;
    ln_v = 1'b0;
    check_frame("t3b", 32'hFFFF_FF00, cap + 1);

    // 4: drops in WAIT_LN, DRAIN and DRAIN exit cycle
    fill_rand();
    for (int k = 0; k < N; k++) send(fr[k]);
    send($urandom());
    send($urandom());
    strobe_ln(32'h0001_8000, cap);
    for (int i = 0; i < N; i++) begin
      sub_v = (i < 3 || i == N - 1);
      sub_d = $urandom();
      tick();
    end
    sub_v = 1'b0;
    tick();
    chk("t4_drops", drop_cnt, 6);
    chk("t4_exit_idle", busy, 1'b0);
    check_frame("t4", 32'h0001_8000, cap + 1);
    fill_rand();
    for (int k = 0; k < N; k++) send(fr[k]);
    strobe_ln(32'hFFFE_0000, cap);
    chk("t4b_nodrop", drop_cnt, 0);
    check_frame("t4b", 32'hFFFE_0000, cap + 1);

    // 5: reset mid-frame with ln already held
    fill_rand();
    for (int k = 0; k < 5; k++) send(fr[k]);
    strobe_ln($urandom(), cap);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_data", nd, 0);
    chk("t5_rst_valid", nv, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", ndone, 0);
    chk("t5_rst_drop", drop, 0);
    rst_n = 1'b1;
    tick();
    clear();
    fill_rand();
    for (int k = 0; k < N; k++) send(fr[k]);
    repeat (4) tick();
    chk("t5_no_early", out_q.size(), 0);
    chk("t5_busy", busy, 1'b1);
    strobe_ln(32'h0000_4000, cap);
    check_frame("t5", 32'h0000_4000, cap + 1);

    // 6: gapped input, late ln
    fill_rand();
    busy_ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      send(fr[k]);
      busy_ok &= busy;
      if (k < N - 1) begin
        repeat (2) begin
          tick();
          busy_ok &= busy;
        end
      end
    end
    repeat (20) begin
      tick();
      busy_ok &= busy;
    end
    chk("t6_busy", busy_ok, 1'b1);
    chk("t6_no_early", out_q.size(), 0);
    strobe_ln(32'h0002_0000, cap);
    check_frame("t6", 32'h0002_0000, cap + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
